// File: rtl/dla_noc_packetizer_if.sv
// Handshake and bus bundle between the DLA packetizer and its neighbours:
// command port, payload stream, router read-buffer write port and grant handshake.
interface dla_noc_packetizer_if #(
  parameter int LEN_W  = 8,
  parameter int DX     = 4,
  parameter int DY     = 4,
  parameter int DL     = 3,
  parameter int DATA_W = 32,
  parameter int LBL_W  = 2
);
  localparam int TOT_W = LBL_W + DATA_W;

  // Handshakes (cmd, pl) transfer on a cycle where valid && ready are both high;
  // valid may not depend on ready, ready may depend on valid.
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [DX-1:0]     cmd_dest_x;
  logic [DY-1:0]     cmd_dest_y;
  logic [DL-1:0]     cmd_dest_l;
  logic [LEN_W-1:0]  cmd_len;

  logic              pl_vld;
  logic              pl_rdy;
  logic [DATA_W-1:0] pl_data;

  logic              rdbuf_wen;
  logic [TOT_W-1:0]  rdbuf_wdata;
  logic              rdbuf_wfull;

  logic              noc2dla_grant_vld;
  logic [10:0]       noc2dla_grant_data;
  logic              noc2dla_grant_ack;
  logic              dla2noc_granted_vld;
  logic [DX-1:0]     dla2noc_granted_x;
  logic [DY-1:0]     dla2noc_granted_y;
  logic [1:0]        dla2noc_granted_dla;

  modport master (
    input  cmd_vld, cmd_dest_x, cmd_dest_y, cmd_dest_l, cmd_len,
    output cmd_rdy,
    input  pl_vld, pl_data,
    output pl_rdy,
    output rdbuf_wen, rdbuf_wdata,
    input  rdbuf_wfull,
    output noc2dla_grant_vld, noc2dla_grant_data,
    input  noc2dla_grant_ack,
    input  dla2noc_granted_vld, dla2noc_granted_x, dla2noc_granted_y, dla2noc_granted_dla
  );

  modport slave (
    output cmd_vld, cmd_dest_x, cmd_dest_y, cmd_dest_l, cmd_len,
    input  cmd_rdy,
    output pl_vld, pl_data,
    input  pl_rdy,
    input  rdbuf_wen, rdbuf_wdata,
    output rdbuf_wfull,
    input  noc2dla_grant_vld, noc2dla_grant_data,
    output noc2dla_grant_ack,
    output dla2noc_granted_vld, dla2noc_granted_x, dla2noc_granted_y, dla2noc_granted_dla
  );
endinterface

// File: rtl/dla_noc_packetizer.sv
// DLA-side NoC transmit engine: grant handshake with timeout/retry, then a
// HEAD flit followed by cmd_len payload flits into the router read buffer.
module dla_noc_packetizer #(
  parameter int LEN_W       = 8,
  parameter int GNT_TIMEOUT = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic                  i_clk_dla,
  input  logic                  i_rst_dla_n,
  dla_noc_packetizer_if.master  bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [2:0]            o_state
);
  localparam int DX     = 4;
  localparam int DY     = 4;
  localparam int DL     = 3;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(GNT_TIMEOUT) + 1;
  localparam int RTY_W  = $clog2(MAX_RETRY + 1) + 1;

  typedef enum logic [1:0] {LBL_BODY = 2'd0, LBL_HEAD = 2'd1, LBL_TAIL = 2'd2} flit_label_t;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT_GNT = 3'd2,
    S_HEAD = 3'd3, S_DATA = 3'd4, S_DRAIN = 3'd5
  } state_t;

  state_t           r_state, w_next;
  logic [DX-1:0]    r_dest_x;
  logic [DY-1:0]    r_dest_y;
  logic [DL-1:0]    r_dest_l;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [RTY_W-1:0] r_retry;
  logic             r_done;
  logic             r_err;

  logic w_accept, w_match, w_timeout, w_retry_ok, w_last;
  flit_label_t w_label;

  assign w_accept   = bus.cmd_vld && bus.cmd_rdy;
  assign w_match    = bus.dla2noc_granted_vld &&
                      (bus.dla2noc_granted_x   == r_dest_x) &&
                      (bus.dla2noc_granted_y   == r_dest_y) &&
                      (bus.dla2noc_granted_dla == r_dest_l[1:0]);
  assign w_timeout  = (r_cnt == CNT_W'(GNT_TIMEOUT - 1));
  assign w_retry_ok = (r_retry < RTY_W'(MAX_RETRY));
  assign w_last     = (r_rem == LEN_W'(1));
  assign w_label    = w_last ? LBL_TAIL : LBL_BODY;

  always_ff @(posedge i_clk_dla or negedge i_rst_dla_n) begin
    if (!i_rst_dla_n) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept && (bus.cmd_len != '0)) w_next = S_REQ;
      S_REQ:      if (bus.noc2dla_grant_ack) w_next = S_WAIT_GNT;
      // A grant arriving in the timeout cycle takes priority over the retry.
      S_WAIT_GNT: if (w_match)        w_next = S_HEAD;
                  else if (w_timeout) w_next = w_retry_ok ? S_REQ : S_DRAIN;
      S_HEAD:     if (bus.rdbuf_wen) w_next = S_DATA;
      S_DATA:     if (bus.rdbuf_wen && w_last) w_next = S_IDLE;
      S_DRAIN:    if (bus.pl_vld && w_last) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_rdy            = (r_state == S_IDLE) && i_rst_dla_n;
    bus.pl_rdy             = 1'b0;
    bus.rdbuf_wen          = 1'b0;
    bus.rdbuf_wdata        = '0;
    bus.noc2dla_grant_vld  = 1'b0;
    bus.noc2dla_grant_data = {r_dest_x, r_dest_y, r_dest_l};
    case (r_state)
      S_REQ:  bus.noc2dla_grant_vld = 1'b1;
      S_HEAD: begin
        bus.rdbuf_wen   = !bus.rdbuf_wfull;
        bus.rdbuf_wdata = {LBL_HEAD, {(DATA_W-11){1'b0}}, r_dest_x, r_dest_y, r_dest_l};
      end
      S_DATA: begin
        bus.pl_rdy      = !bus.rdbuf_wfull;
        bus.rdbuf_wen   = bus.pl_vld && !bus.rdbuf_wfull;
        bus.rdbuf_wdata = {w_label, bus.pl_data};
      end
      S_DRAIN: bus.pl_rdy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk_dla or negedge i_rst_dla_n) begin
    if (!i_rst_dla_n) begin
      r_dest_x <= '0;
      r_dest_y <= '0;
      r_dest_l <= '0;
      r_len    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_retry  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_dest_x <= bus.cmd_dest_x;
          r_dest_y <= bus.cmd_dest_y;
          r_dest_l <= bus.cmd_dest_l;
          r_len    <= bus.cmd_len;
          r_cnt    <= '0;
          r_retry  <= '0;
          r_err    <= (bus.cmd_len == '0);
        end
        S_REQ: if (bus.noc2dla_grant_ack) r_cnt <= '0;
        S_WAIT_GNT: begin
          r_cnt <= r_cnt + 1'b1;
          if (!w_match && w_timeout) begin
            r_cnt <= '0;
            if (w_retry_ok) begin
              r_retry <= r_retry + 1'b1;
            end else begin
              r_rem <= r_len;
              r_err <= 1'b1;
            end
          end
        end
        S_HEAD: if (bus.rdbuf_wen) r_rem <= r_len;
        S_DATA: if (bus.rdbuf_wen) begin
          r_rem  <= r_rem - 1'b1;
          r_done <= w_last;
        end
        // Payload words are swallowed after an abort so the stream stays aligned.
        S_DRAIN: if (bus.pl_vld) r_rem <= r_rem - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = r_done;
  assign o_err   = r_err;
  assign o_state = r_state;
endmodule
